// File: rtl/icap_trig_ctrl.sv
// Reboot trigger sequencer: authorises a request by key, waits a guard delay,
// pulses the ICAP controller enable, then collects the result with bounded retries.
module icap_trig_ctrl #(
  parameter logic [31:0] P_KEY     = 32'hA5_5A_C3_3C,
  parameter logic [15:0] P_GUARD   = 16'd1000,
  parameter logic [7:0]  P_EN_LEN  = 8'd16,
  parameter logic [23:0] P_TIMEOUT = 24'd1_000_000,
  parameter logic [1:0]  P_RETRY   = 2'd2
) (
  input  logic        I_clk,
  input  logic        I_rst,
  input  logic        I_cmd_valid,
  output logic        O_cmd_ready,
  input  logic [31:0] I_cmd_key,
  input  logic        I_cmd_abort,
  output logic        O_icap_en,
  input  logic        I_icap_done,
  input  logic        I_icap_err,
  input  logic        I_st_err,
  output logic        O_busy,
  output logic        O_sts_valid,
  output logic [2:0]  O_sts_code,
  output logic [1:0]  O_retry_cnt
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CHECK  = 3'd1,
    S_GUARD  = 3'd2,
    S_TRIG   = 3'd3,
    S_WAIT   = 3'd4,
    S_RETRY  = 3'd5,
    S_REPORT = 3'd6
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] key_q;
  logic [23:0] cnt_q, cnt_d;
  logic [2:0]  code_d;
  logic [1:0]  retry_q;
  logic        ready_q, en_q, busy_q, sts_valid_q;
  logic [2:0]  sts_code_q;
  logic        accept;

  assign accept = I_cmd_valid && ready_q;

  // One shared counter times GUARD, TRIG and WAIT; it restarts on every state change.
  always_comb begin
    state_d = state_q;
    code_d  = sts_code_q;
    cnt_d   = cnt_q + 24'd1;
    case (state_q)
      S_IDLE: if (accept) state_d = S_CHECK;
      S_CHECK: begin
        if (key_q == P_KEY) begin
          state_d = S_GUARD;
        end else begin
          state_d = S_REPORT;
          code_d  = 3'd2;
        end
      end
      S_GUARD: begin
        if (I_cmd_abort) begin
          state_d = S_REPORT;
          code_d  = 3'd6;
        end else if (cnt_q == {8'd0, P_GUARD - 16'd1}) begin
          state_d = S_TRIG;
        end
      end
      S_TRIG: begin
        if (I_cmd_abort) begin
          state_d = S_REPORT;
          code_d  = 3'd6;
        end else if (cnt_q == {16'd0, P_EN_LEN - 8'd1}) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (I_cmd_abort) begin
          state_d = S_REPORT;
          code_d  = 3'd6;
        end else if (I_st_err) begin
          state_d = S_REPORT;
          code_d  = 3'd4;
        end else if (I_icap_err) begin
          if (retry_q < P_RETRY) begin
            state_d = S_RETRY;
          end else begin
            state_d = S_REPORT;
            code_d  = 3'd3;
          end
        end else if (I_icap_done) begin
          state_d = S_REPORT;
          code_d  = 3'd1;
        end else if (cnt_q == P_TIMEOUT - 24'd1) begin
          if (retry_q < P_RETRY) begin
            state_d = S_RETRY;
          end else begin
            state_d = S_REPORT;
            code_d  = 3'd5;
          end
        end
      end
      S_RETRY:  state_d = S_GUARD;
      S_REPORT: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
    if (state_d != state_q || !(state_q inside {S_GUARD, S_TRIG, S_WAIT})) begin
      cnt_d = 24'd0;
    end
  end

  // Outputs are decoded from the next state so they line up with the state register.
  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      state_q     <= S_IDLE;
      key_q       <= 32'd0;
      cnt_q       <= 24'd0;
      retry_q     <= 2'd0;
      ready_q     <= 1'b0;
      en_q        <= 1'b0;
      busy_q      <= 1'b0;
      sts_valid_q <= 1'b0;
      sts_code_q  <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        key_q   <= I_cmd_key;
        retry_q <= 2'd0;
      end else if (state_q == S_RETRY && retry_q != 2'd3) begin
        retry_q <= retry_q + 2'd1;
      end
      ready_q     <= (state_d == S_IDLE);
      en_q        <= (state_d == S_TRIG);
      busy_q      <= (state_d != S_IDLE);
      sts_valid_q <= (state_d == S_REPORT);
      if (state_d == S_REPORT) sts_code_q <= code_d;
    end
  end

  assign O_cmd_ready = ready_q;
  assign O_icap_en   = en_q;
  assign O_busy      = busy_q;
  assign O_sts_valid = sts_valid_q;
  assign O_sts_code  = sts_code_q;
  assign O_retry_cnt = retry_q;

endmodule

// File: tb/tb_icap_trig_ctrl.sv
// Scoreboard bench for icap_trig_ctrl: stimulus pushes expected results,
// negedge monitors pop and compare whenever a status strobe appears.
module tb_icap_trig_ctrl;

  localparam logic [31:0] KEY = 32'hA55AC33C;

  typedef struct packed {
    logic [2:0] code;
    logic [1:0] retry;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid, ready, abort, en, done, icErr, stErr, busy, sv;
  logic [31:0] key;
  logic [2:0]  code;
  logic [1:0]  retry;

  logic        valid0, ready0, en0, err0, busy0, sv0, zero0;
  logic [31:0] key0;
  logic [2:0]  code0;
  logic [1:0]  retry0;

  exp_t q[$];
  exp_t q0[$];
  int   total = 0;
  int   bad = 0;
  int   riseCnt = 0;
  logic enPrev = 1'b0;

  always #5 clk = ~clk;

  icap_trig_ctrl #(
    .P_KEY(KEY), .P_GUARD(16'd4), .P_EN_LEN(8'd4), .P_TIMEOUT(24'd64), .P_RETRY(2'd2)
  ) u_dut (
    .I_clk(clk), .I_rst(rst), .I_cmd_valid(valid), .O_cmd_ready(ready),
    .I_cmd_key(key), .I_cmd_abort(abort), .O_icap_en(en), .I_icap_done(done),
    .I_icap_err(icErr), .I_st_err(stErr), .O_busy(busy), .O_sts_valid(sv),
    .O_sts_code(code), .O_retry_cnt(retry)
  );

  icap_trig_ctrl #(
    .P_KEY(KEY), .P_GUARD(16'd4), .P_EN_LEN(8'd4), .P_TIMEOUT(24'd64), .P_RETRY(2'd0)
  ) u_dut0 (
    .I_clk(clk), .I_rst(rst), .I_cmd_valid(valid0), .O_cmd_ready(ready0),
    .I_cmd_key(key0), .I_cmd_abort(zero0), .O_icap_en(en0), .I_icap_done(zero0),
    .I_icap_err(err0), .I_st_err(zero0), .O_busy(busy0), .O_sts_valid(sv0),
    .O_sts_code(code0), .O_retry_cnt(retry0)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [31:0] k, input bit holdValid);
    valid = 1'b1;
    key   = k;
    step();
    if (!holdValid) valid = 1'b0;
  endtask

  task automatic waitLevel(input string name, input bit useDut0, input logic level);
    for (int i = 0; i < 200; i++) begin
      if ((useDut0 ? en0 : en) === level) return;
      step();
    end
    checkOutput(name, {31'd0, useDut0 ? en0 : en}, {31'd0, level});
  endtask

  // Status monitors: every strobe must match the oldest pending expectation.
  always @(negedge clk) begin
    exp_t e;
    if (sv) begin
      if (q.size() == 0) begin
        checkOutput("unexpected sts_valid", {31'd0, sv}, 32'd0);
      end else begin
        e = q.pop_front();
        checkOutput("sts_code", {29'd0, code}, {29'd0, e.code});
        checkOutput("sts_retry", {30'd0, retry}, {30'd0, e.retry});
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (sv0) begin
      if (q0.size() == 0) begin
        checkOutput("dut0 unexpected sts_valid", {31'd0, sv0}, 32'd0);
      end else begin
        e = q0.pop_front();
        checkOutput("dut0 sts_code", {29'd0, code0}, {29'd0, e.code});
        checkOutput("dut0 sts_retry", {30'd0, retry0}, {30'd0, e.retry});
      end
    end
  end

  always @(negedge clk) begin
    if (en && !enPrev) riseCnt++;
    enPrev = en;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int  rise0;
    bit  found;
    rst = 1'b1; valid = 1'b0; key = 32'd0; abort = 1'b0; done = 1'b0;
    icErr = 1'b0; stErr = 1'b0;
    valid0 = 1'b0; key0 = KEY; err0 = 1'b0; zero0 = 1'b0;

    // Reset values while reset is held, then ready one clock after release.
    step(); step();
    checkOutput("reset ready", {31'd0, ready}, 32'd0);
    checkOutput("reset en", {31'd0, en}, 32'd0);
    checkOutput("reset busy", {31'd0, busy}, 32'd0);
    checkOutput("reset sts_valid", {31'd0, sv}, 32'd0);
    checkOutput("reset code", {29'd0, code}, 32'd0);
    checkOutput("reset retry", {30'd0, retry}, 32'd0);
    rst = 1'b0;
    step();
    checkOutput("ready after reset", {31'd0, ready}, 32'd1);

    // Good key, done arrives 10 clocks into WAIT.
    applyStimulus(KEY, 1'b0);
    checkOutput("busy after accept", {31'd0, busy}, 32'd1);
    checkOutput("ready after accept", {31'd0, ready}, 32'd0);
    repeat (4) step();
    checkOutput("en low at accept+5", {31'd0, en}, 32'd0);
    step();
    checkOutput("en high at accept+6", {31'd0, en}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      step();
      checkOutput("en held in trig", {31'd0, en}, 32'd1);
    end
    step();
    checkOutput("en low after 4 clocks", {31'd0, en}, 32'd0);
    repeat (9) step();
    done = 1'b1;
    q.push_back('{code: 3'd1, retry: 2'd0});
    step();
    done = 1'b0;
    step();
    checkOutput("idle after done", {31'd0, busy}, 32'd0);
    checkOutput("ready after done", {31'd0, ready}, 32'd1);

    // Wrong key: code 2 two clocks after accept, no enable pulse.
    q.push_back('{code: 3'd2, retry: 2'd0});
    applyStimulus(32'h0, 1'b0);
    checkOutput("badkey en check", {31'd0, en}, 32'd0);
    step();
    checkOutput("badkey sts_valid", {31'd0, sv}, 32'd1);
    checkOutput("badkey en report", {31'd0, en}, 32'd0);
    step();
    checkOutput("badkey en idle", {31'd0, en}, 32'd0);

    // No downstream response: three attempts then timeout code 5.
    rise0 = riseCnt;
    found = 1'b0;
    q.push_back('{code: 3'd5, retry: 2'd2});
    applyStimulus(KEY, 1'b0);
    for (int i = 0; i < 400; i++) begin
      step();
      if (sv) begin
        found = 1'b1;
        break;
      end
    end
    checkOutput("timeout report seen", {31'd0, found}, 32'd1);
    checkOutput("timeout retry_cnt", {30'd0, retry}, 32'd2);
    checkOutput("timeout pulse count", riseCnt - rise0, 32'd3);
    step();
    checkOutput("timeout busy low", {31'd0, busy}, 32'd0);

    // st_err and icap_err together: st_err wins, no retry.
    q.push_back('{code: 3'd4, retry: 2'd0});
    applyStimulus(KEY, 1'b0);
    waitLevel("wait en rise", 1'b0, 1'b1);
    waitLevel("wait en fall", 1'b0, 1'b0);
    icErr = 1'b1; stErr = 1'b1;
    step();
    icErr = 1'b0; stErr = 1'b0;
    checkOutput("sterr report now", {31'd0, sv}, 32'd1);
    checkOutput("sterr no retry", {30'd0, retry}, 32'd0);
    step();

    // icap_err with no retries allowed: code 3.
    q0.push_back('{code: 3'd3, retry: 2'd0});
    valid0 = 1'b1;
    step();
    valid0 = 1'b0;
    waitLevel("dut0 en rise", 1'b1, 1'b1);
    waitLevel("dut0 en fall", 1'b1, 1'b0);
    err0 = 1'b1;
    step();
    err0 = 1'b0;
    checkOutput("dut0 report now", {31'd0, sv0}, 32'd1);
    step();
    checkOutput("dut0 idle", {31'd0, busy0}, 32'd0);

    // Abort in the 2nd TRIG clock, then a fresh command is taken.
    q.push_back('{code: 3'd6, retry: 2'd0});
    applyStimulus(KEY, 1'b0);
    waitLevel("abort en rise", 1'b0, 1'b1);
    step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    checkOutput("en drop after abort", {31'd0, en}, 32'd0);
    checkOutput("abort report", {31'd0, sv}, 32'd1);
    step();
    checkOutput("ready after abort", {31'd0, ready}, 32'd1);
    applyStimulus(KEY, 1'b0);
    checkOutput("new command accepted", {31'd0, busy}, 32'd1);
    step();
    q.push_back('{code: 3'd6, retry: 2'd0});
    abort = 1'b1;
    step();
    abort = 1'b0;
    step();
    checkOutput("idle after guard abort", {31'd0, busy}, 32'd0);

    // Reset in the 3rd TRIG clock with valid held high throughout.
    applyStimulus(KEY, 1'b1);
    checkOutput("held valid ready low", {31'd0, ready}, 32'd0);
    repeat (4) step();
    checkOutput("held en low at +5", {31'd0, en}, 32'd0);
    step();
    checkOutput("held en high at +6", {31'd0, en}, 32'd1);
    step(); step();
    rst = 1'b1;
    step();
    checkOutput("midreset en", {31'd0, en}, 32'd0);
    checkOutput("midreset ready", {31'd0, ready}, 32'd0);
    checkOutput("midreset busy", {31'd0, busy}, 32'd0);
    checkOutput("midreset sts_valid", {31'd0, sv}, 32'd0);
    checkOutput("midreset code", {29'd0, code}, 32'd0);
    checkOutput("midreset retry", {30'd0, retry}, 32'd0);
    rst = 1'b0;
    step();
    checkOutput("post reset ready", {31'd0, ready}, 32'd1);
    checkOutput("post reset not busy", {31'd0, busy}, 32'd0);
    step();
    checkOutput("held valid accepted in idle", {31'd0, busy}, 32'd1);
    valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    repeat (4) step();
    checkOutput("scoreboard drained", q.size(), 32'd0);
    checkOutput("dut0 scoreboard drained", q0.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/icap_trig_ctrl.md
ICAP_TRIG_CTRL -- requirements
Module: icap_trig_ctrl

Interface
REQ-001 The block SHALL have parameter P_KEY, default 32'hA5_5A_C3_3C, the reboot-authorisation key.
REQ-002 The block SHALL have parameter P_GUARD, default 16'd1000, the guard delay in clocks before triggering; legal range 1..65535.
REQ-003 The block SHALL have parameter P_EN_LEN, default 8'd16, the trigger pulse width in clocks; minimum legal value 4.
REQ-004 The block SHALL have parameter P_TIMEOUT, default 24'd1_000_000, the clocks to wait for a result; minimum 1.
REQ-005 The block SHALL have parameter P_RETRY, default 2'd2, the maximum number of retries.
REQ-006 The block SHALL have these ports:
- I_clk  in  1  single clock; all logic on its rising edge.
- I_rst  in  1  reset, synchronous, active-high.
- I_cmd_valid  in  1  reboot request.
- O_cmd_ready  out  1  request accepted when both valid and ready are high.
- I_cmd_key  in  32  key sampled on accept.
- I_cmd_abort  in  1  cancels an in-flight request.
- O_icap_en  out  1  trigger to the downstream ICAP controller enable input.
- I_icap_done  in  1  downstream done status.
- I_icap_err  in  1  downstream ICAP error.
- I_st_err  in  1  downstream state-machine error.
- O_busy  out  1  high whenever the state is not IDLE.
- O_sts_valid  out  1  one-clock result strobe.
- O_sts_code  out  3  result code.
- O_retry_cnt  out  2  retries used by the current or last request.

Function
REQ-007 All outputs SHALL be registered.
REQ-008 The states SHALL be IDLE, CHECK, GUARD, TRIG, WAIT, RETRY and REPORT.
REQ-009 In IDLE, O_cmd_ready SHALL be 1; in every other state it SHALL be 0.
REQ-010 On an accept, I_cmd_key SHALL be latched, O_retry_cnt SHALL be cleared, and the state SHALL go to CHECK.
REQ-011 CHECK SHALL last 1 clock:
- If the latched key equals P_KEY, go to GUARD.
- Otherwise, go to REPORT with code 3'd2, and O_icap_en SHALL never assert.
REQ-012 GUARD SHALL last exactly P_GUARD clocks, then go to TRIG.
REQ-013 In TRIG, O_icap_en SHALL be 1 for exactly P_EN_LEN clocks, then the state SHALL go to WAIT; in every other state O_icap_en SHALL be 0.
REQ-014 On a first attempt, O_icap_en SHALL first be high in the clock P_GUARD+2 clocks after the accept clock.
REQ-015 In WAIT, a 24-bit timeout counter SHALL start from 0 on entry.
REQ-016 In WAIT, events SHALL be evaluated each clock in this priority order:
- I_st_err: go to REPORT with code 3'd4, with no retry.
- I_icap_err: if O_retry_cnt < P_RETRY, go to RETRY; else go to REPORT with code 3'd3.
- I_icap_done: go to REPORT with code 3'd1.
- Counter reaches P_TIMEOUT-1: if O_retry_cnt < P_RETRY, go to RETRY; else go to REPORT with code 3'd5.
REQ-017 RETRY SHALL last 1 clock, increment O_retry_cnt (saturating at 3), and go to GUARD.
REQ-018 I_cmd_abort high in GUARD, TRIG or WAIT SHALL override all other events:
- The state goes to REPORT with code 3'd6.
- If abort arrives in TRIG, O_icap_en SHALL drop in the next clock.
REQ-019 I_cmd_abort in IDLE, CHECK, RETRY or REPORT SHALL be ignored.
REQ-020 REPORT SHALL last 1 clock with O_sts_valid = 1 and O_sts_code set, then go to IDLE.
REQ-021 O_sts_code SHALL hold its value until the next REPORT.
REQ-022 I_cmd_valid while busy SHALL be ignored: not queued, and with no side effects.
REQ-023 Downstream status inputs outside WAIT SHALL be ignored.
REQ-024 An illegal state encoding SHALL recover to IDLE on the next clock.
REQ-025 Each retry SHALL produce a fresh low-to-high transition on O_icap_en, separated from the previous pulse by at least P_GUARD+2 low clocks.

Reset
REQ-026 While I_rst is high, the outputs SHALL be: state IDLE, O_cmd_ready = 0, O_icap_en = 0, O_busy = 0, O_sts_valid = 0, O_sts_code = 0, O_retry_cnt = 0, and all counters 0.
REQ-027 O_cmd_ready SHALL become 1 in the first clock after I_rst falls.
REQ-028 Reset asserted mid-operation (including during TRIG) SHALL take effect on the next clock edge:
- O_icap_en = 0.
- No O_sts_valid is produced for the interrupted request.

Verification
REQ-029 The bench SHALL use P_GUARD=4, P_EN_LEN=4, P_TIMEOUT=64, P_RETRY=2 and cover these scenarios:
- Good key, I_icap_done pulsed 10 clocks into WAIT -> O_icap_en high for exactly 4 clocks starting 6 clocks after accept; one O_sts_valid with code 1 and retry_cnt 0.
- Key 32'h0 -> code 2 two clocks after accept; O_icap_en stays 0 throughout.
- Good key, no downstream response -> 3 pulses on O_icap_en; final code 5; O_retry_cnt = 2; O_busy = 0 after REPORT.
- I_icap_err and I_st_err asserted in the same WAIT clock -> code 4 and no retry; then I_icap_err alone with P_RETRY=0 -> code 3.
- I_cmd_abort in the 2nd TRIG clock -> O_icap_en low next clock; code 6; a new command is accepted afterwards.
- Reset in the 3rd TRIG clock -> all outputs at reset values next clock; no O_sts_valid; I_cmd_valid held high during busy is not accepted until IDLE.
